// File: rtl/fadd_pkg.sv
// Shared types and helpers for the vector FP-add sequencer.
package fadd_pkg;

  localparam int FFLAGS_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int elem_w(input int expwidth, input int precision);
    return expwidth + precision + 1;
  endfunction

endpackage

// File: rtl/fadd_lane_pick.sv
// Priority encoder: lowest set bit index plus a found flag.
module fadd_lane_pick
  import fadd_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     bits,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top so the lowest set index is the last one written
  always_comb begin
    idx   = {IDX_W{1'b0}};
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx   = bits[i] ? IDX_W'(i) : idx;
      found = found | bits[i];
    end
  end

endmodule

// File: rtl/fadd_vec_seq.sv
// Issues the active lanes of one vector add into the scalar FP adder and
// assembles the in-order results into a single writeback.
module fadd_vec_seq
  import fadd_pkg::*;
#(
  parameter int EXPWIDTH        = 5,
  parameter int PRECISION       = 3,
  parameter int NUM_LANE        = 4,
  parameter int DEPTH_WARP      = 4,
  parameter int MAX_OUTSTANDING = 2,
  localparam int W = elem_w(EXPWIDTH, PRECISION)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [NUM_LANE*W-1:0]   req_a_i,
  input  logic [NUM_LANE*W-1:0]   req_b_i,
  input  logic [NUM_LANE-1:0]     req_mask_i,
  input  logic [2:0]              req_rm_i,
  input  logic [7:0]              req_reg_idxw_i,
  input  logic [DEPTH_WARP-1:0]   req_warpid_i,
  output logic                    fu_valid_o,
  input  logic                    fu_ready_i,
  output logic [W-1:0]            fu_a_o,
  output logic [W-1:0]            fu_b_o,
  output logic [2:0]              fu_rm_o,
  input  logic                    fu_out_valid_i,
  output logic                    fu_out_ready_o,
  input  logic [W-1:0]            fu_result_i,
  input  logic [FFLAGS_W-1:0]     fu_fflags_i,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [NUM_LANE*W-1:0]   wb_data_o,
  output logic [FFLAGS_W-1:0]     wb_fflags_o,
  output logic [NUM_LANE-1:0]     wb_mask_o,
  output logic [7:0]              wb_reg_idxw_o,
  output logic [DEPTH_WARP-1:0]   wb_warpid_o
);

  localparam int IDX_W = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] ONE_OUT = OUT_W'(1'b1);

  state_e                  state_r, next_state_s;
  logic [NUM_LANE*W-1:0]   a_r, b_r, data_r;
  logic [NUM_LANE-1:0]     mask_r, issued_r, collected_r;
  logic [2:0]              rm_r;
  logic [7:0]              reg_idxw_r;
  logic [DEPTH_WARP-1:0]   warpid_r;
  logic [OUT_W-1:0]        outstanding_r;
  logic [FFLAGS_W-1:0]     fflags_r;

  logic [NUM_LANE-1:0]     pend_issue_s, pend_col_s, issue_onehot_s, col_onehot_s;
  logic [IDX_W-1:0]        issue_ptr_s, col_ptr_s;
  logic                    issue_found_s, col_found_s;
  logic                    accept_s, issue_fire_s, col_fire_s, last_col_s;

  assign pend_issue_s   = mask_r & ~issued_r;
  assign pend_col_s     = mask_r & ~collected_r;
  assign issue_onehot_s = NUM_LANE'(1'b1) << issue_ptr_s;
  assign col_onehot_s   = NUM_LANE'(1'b1) << col_ptr_s;

  fadd_lane_pick #(.N(NUM_LANE)) u_issue_pick (
    .bits  (pend_issue_s),
    .idx   (issue_ptr_s),
    .found (issue_found_s)
  );

  fadd_lane_pick #(.N(NUM_LANE)) u_col_pick (
    .bits  (pend_col_s),
    .idx   (col_ptr_s),
    .found (col_found_s)
  );

  assign accept_s     = req_valid_i && req_ready_o;
  assign issue_fire_s = fu_valid_o && fu_ready_i;
  assign col_fire_s   = fu_out_valid_i && fu_out_ready_o && col_found_s;
  assign last_col_s   = ((pend_col_s & ~col_onehot_s) == {NUM_LANE{1'b0}});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = (req_mask_i == {NUM_LANE{1'b0}}) ? DONE : BUSY;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (col_fire_s && last_col_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = BUSY;
        end
      end
      DONE: begin
        if (wb_ready_i) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    req_ready_o    = 1'b0;
    fu_valid_o     = 1'b0;
    fu_out_ready_o = 1'b0;
    wb_valid_o     = 1'b0;
    case (state_r)
      IDLE: req_ready_o = 1'b1;
      BUSY: begin
        fu_valid_o     = issue_found_s && (outstanding_r < MAX_OUT);
        fu_out_ready_o = (outstanding_r != {OUT_W{1'b0}});
      end
      DONE:    wb_valid_o  = 1'b1;
      default: req_ready_o = 1'b0;
    endcase
  end

  // Request latch, issue/collect bookkeeping and result assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r           <= {(NUM_LANE*W){1'b0}};
      b_r           <= {(NUM_LANE*W){1'b0}};
      data_r        <= {(NUM_LANE*W){1'b0}};
      mask_r        <= {NUM_LANE{1'b0}};
      issued_r      <= {NUM_LANE{1'b0}};
      collected_r   <= {NUM_LANE{1'b0}};
      rm_r          <= 3'd0;
      reg_idxw_r    <= 8'd0;
      warpid_r      <= {DEPTH_WARP{1'b0}};
      outstanding_r <= {OUT_W{1'b0}};
      fflags_r      <= {FFLAGS_W{1'b0}};
    end else if (accept_s) begin
      a_r           <= req_a_i;
      b_r           <= req_b_i;
      data_r        <= {(NUM_LANE*W){1'b0}};
      mask_r        <= req_mask_i;
      issued_r      <= {NUM_LANE{1'b0}};
      collected_r   <= {NUM_LANE{1'b0}};
      rm_r          <= req_rm_i;
      reg_idxw_r    <= req_reg_idxw_i;
      warpid_r      <= req_warpid_i;
      outstanding_r <= {OUT_W{1'b0}};
      fflags_r      <= {FFLAGS_W{1'b0}};
    end else begin
      if (issue_fire_s) begin
        issued_r <= issued_r | issue_onehot_s;
      end
      if (col_fire_s) begin
        collected_r                <= collected_r | col_onehot_s;
        data_r[col_ptr_s*W +: W]   <= fu_result_i;
        fflags_r                   <= fflags_r | fu_fflags_i;
      end
      // Simultaneous issue and collect leave the count unchanged
      case ({issue_fire_s, col_fire_s})
        2'b10:   outstanding_r <= outstanding_r + ONE_OUT;
        2'b01:   outstanding_r <= outstanding_r - ONE_OUT;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  assign fu_a_o        = a_r[issue_ptr_s*W +: W];
  assign fu_b_o        = b_r[issue_ptr_s*W +: W];
  assign fu_rm_o       = rm_r;
  assign wb_data_o     = data_r;
  assign wb_fflags_o   = fflags_r;
  assign wb_mask_o     = mask_r;
  assign wb_reg_idxw_o = reg_idxw_r;
  assign wb_warpid_o   = warpid_r;

endmodule
